// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a single-outstanding load/store
// port, producing the MTIP level with its change strobe and the MSIP level.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clint_req_valid_i,
  output logic              clint_req_ready_o,
  input  logic              clint_req_wen_i,
  input  logic [ADDR_W-1:0] clint_req_addr_i,
  input  logic [63:0]       clint_req_wdata_i,
  input  logic [7:0]        clint_req_wstrb_i,
  output logic              clint_resp_valid_o,
  input  logic              clint_resp_ready_i,
  output logic [63:0]       clint_resp_rdata_o,
  output logic              clint_resp_err_o,
  output logic              clint_mtip_o,
  output logic              clint_update_o,
  output logic              clint_msip_o
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  localparam logic [ADDR_W-1:0] A_MSIP  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_CMP   = ADDR_W'(BASE_ADDR + 64'h4000);
  localparam logic [ADDR_W-1:0] A_MTIME = ADDR_W'(BASE_ADDR + 64'hBFF8);
  localparam logic [15:0]       TICK_LAST = 16'(TICK_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_mtime, r_mtimecmp, r_rdata;
  logic [15:0] r_presc;
  logic        r_msip, r_err, r_mtip, r_update;

  logic        w_accept, w_tick, w_cmp, w_err;
  logic        w_hit_msip, w_hit_cmp, w_hit_mtime;
  logic        w_wr_msip, w_wr_cmp, w_wr_mtime;
  logic [63:0] w_rdata, w_mtime_inc, w_mtime_nxt;
  logic        w_unused;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++)
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    return res;
  endfunction

  // Decode ignores the byte offset within the doubleword.
  assign w_hit_msip  = clint_req_addr_i[ADDR_W-1:3] == A_MSIP[ADDR_W-1:3];
  assign w_hit_cmp   = clint_req_addr_i[ADDR_W-1:3] == A_CMP[ADDR_W-1:3];
  assign w_hit_mtime = clint_req_addr_i[ADDR_W-1:3] == A_MTIME[ADDR_W-1:3];
  assign w_unused    = ^clint_req_addr_i[2:0];

  assign w_accept   = clint_req_valid_i && (r_state == S_IDLE);
  assign w_wr_msip  = w_accept && clint_req_wen_i && w_hit_msip && clint_req_wstrb_i[0];
  assign w_wr_cmp   = w_accept && clint_req_wen_i && w_hit_cmp;
  assign w_wr_mtime = w_accept && clint_req_wen_i && w_hit_mtime;

  assign w_tick      = (r_presc == TICK_LAST);
  assign w_mtime_inc = r_mtime + 64'(w_tick);
  // Stored bytes override the same-edge increment; unstored bytes keep it.
  assign w_mtime_nxt = w_wr_mtime ? merge_bytes(w_mtime_inc, clint_req_wdata_i, clint_req_wstrb_i)
                                  : w_mtime_inc;
  assign w_cmp       = (r_mtime >= r_mtimecmp);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RESP;
      S_RESP:  if (clint_resp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_err   = !(w_hit_msip || w_hit_cmp || w_hit_mtime);
    w_rdata = '0;
    if (!clint_req_wen_i) begin
      if (w_hit_msip)       w_rdata = {63'b0, r_msip};
      else if (w_hit_cmp)   w_rdata = r_mtimecmp;
      else if (w_hit_mtime) w_rdata = r_mtime;
    end
  end

  // NOTE: state uses non-blocking assignments and a reset sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_presc    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_mtip     <= 1'b0;
      r_update   <= 1'b0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      r_mtime <= w_mtime_nxt;
      if (w_wr_cmp)
        r_mtimecmp <= merge_bytes(r_mtimecmp, clint_req_wdata_i, clint_req_wstrb_i);
      if (w_wr_msip)
        r_msip <= clint_req_wdata_i[0];
      if (w_accept) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
      r_mtip   <= w_cmp;
      r_update <= (w_cmp != r_mtip);
    end
  end

  assign clint_req_ready_o  = (r_state == S_IDLE);
  assign clint_resp_valid_o = (r_state == S_RESP);
  assign clint_resp_rdata_o = r_rdata;
  assign clint_resp_err_o   = r_err;
  assign clint_mtip_o       = r_mtip;
  assign clint_update_o     = r_update;
  assign clint_msip_o       = r_msip;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus random traffic, scored against a
// cycle-level reference of the timer rules with a queue of expected responses.
module tb_clint_timer;

  localparam logic [63:0] BASE    = 64'h0000_0000_0200_0000;
  localparam int          TD      = 1;
  localparam logic [63:0] A_MSIP  = BASE;
  localparam logic [63:0] A_CMP   = BASE + 64'h4000;
  localparam logic [63:0] A_MTIME = BASE + 64'hBFF8;
  localparam logic [63:0] A_BAD   = BASE + 64'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err, mtip, update, msip;
  logic [63:0] resp_rdata;

  clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .clint_req_valid_i(req_valid), .clint_req_ready_o(req_ready),
    .clint_req_wen_i(req_wen), .clint_req_addr_i(req_addr),
    .clint_req_wdata_i(req_wdata), .clint_req_wstrb_i(req_wstrb),
    .clint_resp_valid_o(resp_valid), .clint_resp_ready_i(resp_ready),
    .clint_resp_rdata_o(resp_rdata), .clint_resp_err_o(resp_err),
    .clint_mtip_o(mtip), .clint_update_o(update), .clint_msip_o(msip)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [63:0] rdata; logic err; } resp_t;
  resp_t exp_q[$];

  // Reference state: architectural registers and the visible interrupt outputs.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_busy, m_mtip, m_update;
  int          m_presc;
  bit          started = 0;

  function automatic logic [63:0] apply_strb(input logic [63:0] cur, input logic [63:0] d,
                                             input logic [7:0] s);
    logic [63:0] r = cur;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [63:0] a, new_time;
    logic        tick, cmp;
    resp_t       r;
    if (!rst) begin
      m_mtime = '0; m_cmp = '1; m_msip = 0; m_presc = 0;
      m_busy = 0; m_mtip = 0; m_update = 0;
      exp_q.delete();
      started = 1;
    end else begin
      cmp      = (m_mtime >= m_cmp);
      tick     = (m_presc == TD - 1);
      new_time = tick ? m_mtime + 64'd1 : m_mtime;
      if (req_valid && !m_busy) begin
        a = {req_addr[63:3], 3'b000};
        r = '{rdata: 64'd0, err: 1'b0};
        if (a == A_MSIP) begin
          if (req_wen) begin if (req_wstrb[0]) m_msip = req_wdata[0]; end
          else r.rdata = {63'd0, m_msip};
        end else if (a == A_CMP) begin
          if (req_wen) m_cmp = apply_strb(m_cmp, req_wdata, req_wstrb);
          else r.rdata = m_cmp;
        end else if (a == A_MTIME) begin
          if (req_wen) new_time = apply_strb(new_time, req_wdata, req_wstrb);
          else r.rdata = m_mtime;
        end else r.err = 1'b1;
        exp_q.push_back(r);
        m_busy = 1;
      end else if (m_busy && resp_ready) m_busy = 0;
      m_mtime  = new_time;
      m_presc  = tick ? 0 : m_presc + 1;
      m_update = (cmp != m_mtip);
      m_mtip   = cmp;
    end
  end

  // Monitor: sample outputs mid-cycle, pop one expected response per transaction.
  resp_t cur;
  bit    have_cur = 0;
  always @(negedge clk) begin
    if (started) begin
      check("req_ready",  req_ready,  !m_busy);
      check("resp_valid", resp_valid, m_busy);
      check("mtip",       mtip,       m_mtip);
      check("update",     update,     m_update);
      check("msip",       msip,       m_msip);
      if (!rst) have_cur = 0;
      else if (resp_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
          else begin cur = exp_q.pop_front(); have_cur = 1; end
        end
        if (have_cur) begin
          check("rdata", resp_rdata, cur.rdata);
          check("err",   resp_err,   cur.err);
          if (resp_ready) have_cur = 0;
        end
      end
    end
  end

  // Response backpressure: random unless the directed sequence pins it.
  bit rr_force = 1, rr_val = 1;
  initial forever begin
    @(posedge clk); #1;
    resp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
  end

  task automatic do_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb);
    int  waited = 0;
    bit  done = 0;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1;
      else if (++waited > 50) begin check("req_timeout", 0, 1); done = 1; end
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((m_busy || have_cur || exp_q.size() != 0) && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    check("idle_timeout", (waited >= 200), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    // Load right out of reset, then another a few cycles later.
    do_req(0, A_MTIME, 0, 0);
    repeat (4) @(posedge clk); #1;
    do_req(0, A_MTIME + 64'd5, 0, 0);
    do_req(0, A_CMP, 0, 0);
    wait_idle();
    // Timer compare rises, then clears on a store of all-ones.
    do_req(1, A_CMP, 64'd20, 8'hFF);
    repeat (30) @(posedge clk); #1;
    do_req(1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    repeat (4) @(posedge clk); #1;
    // mtime wrap with mtimecmp=0 keeps mtip high.
    do_req(1, A_CMP, 64'd0, 8'hFF);
    do_req(1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    do_req(0, A_MTIME, 0, 0);
    do_req(0, A_MTIME, 0, 0);
    wait_idle();
    // Unmapped store held under backpressure, followed immediately by a load.
    rr_val = 0;
    do_req(1, A_BAD, 64'hDEAD_BEEF, 8'hFF);
    repeat (3) @(posedge clk); #1;
    rr_val = 1;
    do_req(0, A_MSIP, 0, 0);
    wait_idle();
    // Software interrupt, then a reset in the middle of a response.
    do_req(1, A_MSIP, 64'd1, 8'h01);
    wait_idle();
    rr_val = 0;
    do_req(0, A_MTIME, 0, 0);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_msip", msip, 0);
    check("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rr_val = 1;
    // Random traffic with random backpressure.
    rr_force = 0;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a, d;
      case ($urandom_range(0, 4))
        0: a = A_MSIP;
        1, 2: a = A_CMP;
        3: a = A_MTIME;
        default: a = ($urandom_range(0, 1) != 0) ? A_BAD : BASE + 64'h8000;
      endcase
      a = a | 64'($urandom_range(0, 7));
      d = ($urandom_range(0, 2) != 0) ? 64'(m_mtime + 64'($urandom_range(0, 60)))
                                      : {$urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), a, d,
             ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rr_force = 1; rr_val = 1;
    wait_idle();
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
